mu0_mem_loader_dp: RTL and testbench
====================================

// Module: mu0_mem_loader_dp
// PURPOSE
// - Program/data memory for the MU0 CPU, plus a boot loader.
// - Dual-port 4096x16 synchronous RAM. Port A is read/write for instruction fetch and
//   LDA/ADD/SUB/STO. Port B is read-only (address2/readdata2 look-ahead path). Reads on
//   both ports have one cycle of latency.
// - After reset, a valid/ready word stream fills memory from address 0 while the CPU is
//   held in reset. The CPU is then released.
// PARAMETERS
// - ADDR_W  12    address width; depth = 2**ADDR_W words
// - DATA_W  16    word width
// PORTS
// - clk        in   1       clock; all state updates on posedge
// - rst        in   1       reset, synchronous, active-high
// - address    in   ADDR_W  port A address from the CPU
// - read       in   1       port A read strobe
// - write      in   1       port A write strobe
// - writedata  in   DATA_W  port A write data
// - readdata   out  DATA_W  port A registered read data
// - address2   in   ADDR_W  port B address
// - readdata2  out  DATA_W  port B registered read data
// - ld_valid   in   1       loader word valid
// - ld_data    in   DATA_W  loader word
// - ld_last    in   1       qualifies the final loader word
// - ld_ready   out  1       loader can accept a word
// - cpu_rst    out  1       reset for the CPU; high until the load completes
// - ld_done    out  1       load complete, CPU running
// - ld_count   out  ADDR_W+1  number of words loaded (0..2**ADDR_W)
// BEHAVIOUR
// - Reset values:
//   - state=LOAD, ld_ptr=0, ld_count=0
//   - readdata=0, readdata2=0, cpu_rst=1, ld_done=0
//   - ld_ready=1 on the first cycle after reset.
//   - RAM contents are NOT cleared by rst.
// - LOAD state:
//   - ld_ready=1.
//   - Each cycle with ld_valid&&ld_ready: mem[ld_ptr]<=ld_data, ld_ptr++, ld_count++.
//   - Accepting a word with ld_last=1, or accepting the word at ld_ptr=2**ADDR_W-1
//     (wrap guard; ld_ptr never wraps) -> START.
//   - Port A/B inputs are ignored: no writes, readdata/readdata2 hold 0.
// - START state (exactly 1 cycle):
//   - ld_ready=0, cpu_rst=1. This guarantees the CPU sees one more rst edge after the
//     last word is written.
//   - Next state is RUN.
// - RUN state (terminal until rst):
//   - cpu_rst=0, ld_done=1, ld_ready=0. ld_valid is ignored.
//   - Port A write: at the edge where write=1, mem[address]<=writedata.
//   - Port A read: at the edge where read=1, readdata<=mem[address], visible the next
//     cycle. When read=0, readdata holds its last value.
//   - read&&write in the same cycle: the write is performed; readdata<=old contents
//     (read-before-write).
//   - Port B: readdata2<=mem[address2] every cycle; no strobe.
// - Reset mid-load or mid-run:
//   - Returns to LOAD with ld_ptr=0 and cpu_rst=1.
//   - Words already written remain in RAM until overwritten.
// - Latency:
//   - Data for an address presented in cycle N is valid in cycle N+1.
//   - Writes are visible to reads issued in cycle N+1 and later.
// CONFIGURATION
// - WRITE_FORWARD_EN defined:
//   - In RUN, if write=1 and address2==address in the same cycle,
//     readdata2<=writedata (new data).
// - WRITE_FORWARD_EN undefined:
//   - In the same case, readdata2<=old mem[address2].
// - Port A always returns old data on a same-cycle read/write in both builds.
// TESTING
// - Stream 3 words 0x0005,0x7000,0x1234 (last on 3rd) -> mem[0..2] match; ld_count=3;
//   START 1 cycle; cpu_rst falls 2 cycles after the 3rd accept.
// - ld_valid gapped (1,0,0,1 with last) -> only 2 words written, ld_count=2,
//   ld_ptr holds during the gaps.
// - RUN: write addr 0x010 data 0xBEEF, then read 0x010 next cycle -> readdata=0xBEEF
//   one cycle later; read=0 afterwards -> readdata holds 0xBEEF.
// - RUN: write 0x020<=0x0001 with address2=0x020 in the same cycle -> readdata2=old
//   value (or 0x0001 with WRITE_FORWARD_EN); next cycle readdata2=0x0001.
// - Stream 4096 words, no last -> transition to START after the 4096th; ld_count=4096;
//   mem[0] not overwritten.
// - Assert rst after loading 2 words -> cpu_rst=1, ld_count=0, ld_ready=1; mem[0..1] retain
//   the loaded data.

Source files
------------

// File: rtl/mu0_mem_loader_dp.sv
// mu0_mem_loader_dp: 4096x16 dual-port program/data RAM for the MU0 CPU
// with a streaming boot loader in front of it.
//
// Handshake: a loader word transfers on any rising edge where
// ld_valid && ld_ready; ld_ready is high only in LOAD and does not depend on
// ld_valid. Synchronous rst dominates, so no word is written on a reset edge.
//
// Sequencing: LOAD (stream words from address 0) -> START (one cycle, CPU
// still in reset) -> RUN (CPU owns port A, port B free-running).
// The FSM state is observable as {cpu_rst, ld_ready}: LOAD=11, START=10,
// RUN=00.
//
// Optional build macro: WRITE_FORWARD_EN. When defined, port B returns the
// new write data on a same-cycle port A write to the same address. Otherwise
// port B returns the old contents.
module mu0_mem_loader_dp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [ADDR_W-1:0] address2,
  output logic [DATA_W-1:0] readdata2,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ld_ptr;
  logic              ld_accept;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state and output decode for the load/start/run sequencer.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    cpu_rst   = 1'b1;
    ld_done   = 1'b0;
    ld_accept = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready  = 1'b1;
        ld_accept = ld_valid;
        // The last addressable word also ends the load so ld_ptr never wraps.
        if (ld_valid && (ld_last || (ld_ptr == PTR_MAX))) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        // One extra cycle of CPU reset after the final word is in RAM.
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        ld_done = 1'b1;
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Load pointer and word counter; the pointer saturates at the top address.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ptr   <= '0;
      ld_count <= '0;
    end else if (ld_accept) begin
      ld_count <= ld_count + CNT_ONE;
      if (ld_ptr != PTR_MAX) begin
        ld_ptr <= ld_ptr + PTR_ONE;
      end
    end
  end

  // Single RAM write port shared by the loader (LOAD) and CPU port A (RUN).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_ptr;
    mem_wdata = ld_data;
    if (!rst) begin
      if (state == S_RUN) begin
        mem_we    = write;
        mem_waddr = address;
        mem_wdata = writedata;
      end else begin
        mem_we    = ld_accept;
      end
    end
  end

  // RAM array; contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Port A registered read, strobed; old data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
    end else if ((state == S_RUN) && read) begin
      readdata <= mem[address];
    end
  end

  // Port B registered read every RUN cycle, with optional write forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata2 <= '0;
    end else if (state == S_RUN) begin
`ifdef WRITE_FORWARD_EN
      if (write && (address2 == address)) begin
        readdata2 <= writedata;
      end else begin
        readdata2 <= mem[address2];
      end
`else
      readdata2 <= mem[address2];
`endif
    end
  end

endmodule

// File: tb/tb_mu0_mem_loader_dp.sv
// tb_mu0_mem_loader_dp: self-checking bench for mu0_mem_loader_dp.
// A behavioural model (phase, word count, shadow memory with known flags)
// predicts every output; a negedge compare process checks the DUT against it
// each cycle, and the directed scenarios add hand-computed literal checks.
module tb_mu0_mem_loader_dp;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic [ADDR_W-1:0] address2 = '0;
  logic [DATA_W-1:0] readdata2;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              cpu_rst;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;

  int n_checks = 0;
  int n_errors = 0;

  mu0_mem_loader_dp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata),
    .address2(address2), .readdata2(readdata2),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_rst(cpu_rst), .ld_done(ld_done),
    .ld_count(ld_count)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 loading, 1 the single hold cycle, 2 CPU running.
  int                m_phase = 0;
  int                m_count = 0;
  bit                m_live  = 1'b0;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];
  logic [DATA_W-1:0] e_rd  = '0;
  bit                e_rd_k  = 1'b1;
  logic [DATA_W-1:0] e_rd2 = '0;
  bit                e_rd2_k = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_live  = 1'b1;
      m_phase = 0;
      m_count = 0;
      e_rd = '0;  e_rd_k  = 1'b1;
      e_rd2 = '0; e_rd2_k = 1'b1;
    end else if (m_live) begin
      if (m_phase == 0) begin
        if (ld_valid) begin
          m_mem[m_count]   = ld_data;
          m_known[m_count] = 1'b1;
          m_count++;
          if (ld_last || m_count == DEPTH) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (read) begin
          e_rd   = m_mem[address];
          e_rd_k = m_known[address];
        end
`ifdef WRITE_FORWARD_EN
        if (write && address2 == address) begin
          e_rd2 = writedata; e_rd2_k = 1'b1;
        end else begin
          e_rd2 = m_mem[address2]; e_rd2_k = m_known[address2];
        end
`else
        e_rd2   = m_mem[address2];
        e_rd2_k = m_known[address2];
`endif
        if (write) begin
          m_mem[address]   = writedata;
          m_known[address] = 1'b1;
        end
      end
    end
  end

  // Scoreboard compare on every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("ld_ready",  32'(ld_ready), 32'(m_phase == 0));
      chk("cpu_rst",   32'(cpu_rst),  32'(m_phase != 2));
      chk("ld_done",   32'(ld_done),  32'(m_phase == 2));
      chk("ld_count",  32'(ld_count), 32'(m_count));
      if (e_rd_k)  chk("readdata",  32'(readdata),  32'(e_rd));
      if (e_rd2_k) chk("readdata2", 32'(readdata2), 32'(e_rd2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_last = 1'b0;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic port_a(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] a2);
    read = r; write = w; address = a; writedata = wd; address2 = a2;
    cyc();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      port_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom),
             ADDR_W'($urandom_range(0, 31)));
    end
    idle();
  endtask

  logic [DATA_W-1:0] first_word;

  initial begin
    // Reset state.
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rst_ld_count", 32'(ld_count), 32'd0);
    chk("rst_readdata", 32'(readdata), 32'd0);
    rst = 1'b0;
    chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);

    // Three-word stream with last on the third.
    load_word(16'h0005, 1'b0);
    load_word(16'h7000, 1'b0);
    load_word(16'h1234, 1'b1);
    chk("start_ld_ready", 32'(ld_ready), 32'd0);
    chk("start_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("start_ld_count", 32'(ld_count), 32'd3);
    cyc();
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_ld_done", 32'(ld_done), 32'd1);
    port_a(1'b1, 1'b0, 12'h000, 16'h0, 12'h002);
    chk("mem0", 32'(readdata), 32'h0005);
    chk("mem2_portb", 32'(readdata2), 32'h1234);
    port_a(1'b1, 1'b0, 12'h001, 16'h0, 12'h000);
    chk("mem1", 32'(readdata), 32'h7000);
    port_a(1'b1, 1'b0, 12'h002, 16'h0, 12'h001);
    chk("mem2", 32'(readdata), 32'h1234);

    // Write then read back; readdata holds when read drops.
    port_a(1'b0, 1'b1, 12'h010, 16'hBEEF, 12'h000);
    port_a(1'b1, 1'b0, 12'h010, 16'h0, 12'h000);
    chk("beef_read", 32'(readdata), 32'hBEEF);
    port_a(1'b0, 1'b0, 12'h000, 16'h0, 12'h000);
    chk("beef_hold", 32'(readdata), 32'hBEEF);

    // Port B same-cycle collision with a port A write.
    port_a(1'b0, 1'b1, 12'h020, 16'h5555, 12'h000);
    port_a(1'b1, 1'b1, 12'h020, 16'h0001, 12'h020);
`ifdef WRITE_FORWARD_EN
    chk("fwd_portb", 32'(readdata2), 32'h0001);
`else
    chk("fwd_portb", 32'(readdata2), 32'h5555);
`endif
    chk("rbw_porta", 32'(readdata), 32'h5555);
    port_a(1'b0, 1'b0, 12'h000, 16'h0, 12'h020);
    chk("portb_after", 32'(readdata2), 32'h0001);

    random_run(300);

    // Reset mid-load: loaded words survive.
    do_reset();
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    chk("two_loaded", 32'(ld_count), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("midrst_ld_count", 32'(ld_count), 32'd0);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
    load_word(16'hCCCC, 1'b1);
    cyc();
    port_a(1'b1, 1'b0, 12'h001, 16'h0, 12'h000);
    chk("retain_mem1", 32'(readdata), 32'hBBBB);
    chk("reload_mem0", 32'(readdata2), 32'hCCCC);
    idle();

    // Gapped valid: 1,0,0,1(last).
    do_reset();
    load_word(16'h1111, 1'b0);
    cyc();
    chk("gap_hold1", 32'(ld_count), 32'd1);
    cyc();
    chk("gap_hold2", 32'(ld_count), 32'd1);
    load_word(16'h2222, 1'b1);
    chk("gap_count", 32'(ld_count), 32'd2);
    cyc();
    port_a(1'b1, 1'b0, 12'h001, 16'h0, 12'h000);
    chk("gap_mem1", 32'(readdata), 32'h2222);
    chk("gap_mem0", 32'(readdata2), 32'h1111);
    idle();

    // Randomized gapped loads followed by random RUN traffic.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(4, 24);
      do_reset();
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0) cyc();
        load_word(DATA_W'($urandom), 1'(i == n - 1));
      end
      cyc();
      random_run(150);
    end

    // Full 4096-word stream without last.
    do_reset();
    first_word = DATA_W'($urandom);
    load_word(first_word, 1'b0);
    for (int i = 1; i < DEPTH; i++) load_word(DATA_W'($urandom), 1'b0);
    chk("full_count", 32'(ld_count), 32'd4096);
    chk("full_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1; ld_data = 16'hFFFF;
    cyc();
    cyc();
    idle();
    chk("full_done", 32'(ld_done), 32'd1);
    port_a(1'b1, 1'b0, 12'h000, 16'h0, 12'hFFF);
    chk("full_mem0", 32'(readdata), 32'(first_word));
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
